// File: rtl/matmul_c_drain.sv
// rtl/matmul_c_drain.sv - de-skews the tile's diagonal C row streams into whole-row C memory writes
module matmul_c_drain #(
    parameter int DWIDTH        = 16,
    parameter int AWIDTH        = 7,
    parameter int N             = 4,
    parameter int FIRST_CAPTURE = 19,
    parameter int C_BASE        = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_mat_mul,
    input  logic [N*DWIDTH-1:0]   c_data_in,
    output logic [AWIDTH-1:0]     c_addr,
    output logic [N*DWIDTH-1:0]   c_data,
    output logic                  c_we,
    output logic                  done_drain
);

    localparam int RW       = (N > 1) ? $clog2(N) : 1;
    localparam int LAST_CAP = FIRST_CAPTURE + 2*N - 2;
    localparam int ROW0_END = FIRST_CAPTURE + N - 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [7:0]              r_cnt;
    logic [DWIDTH-1:0]       r_buf [N][N];
    logic [AWIDTH-1:0]       r_addr;
    logic [N*DWIDTH-1:0]     r_data;
    logic                    r_we;
    logic                    r_done;

    int                      w_row_i;
    logic [RW-1:0]           w_row;
    logic                    w_wr_en;
    logic                    w_capture;
    logic [N*DWIDTH-1:0]     w_row_word;
    logic [31:0]             w_addr_full;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (int'(r_cnt) == FIRST_CAPTURE - 1) ? CAPTURE : WAIT;
            WAIT:    if (int'(r_cnt) == FIRST_CAPTURE - 1) w_next = CAPTURE;
            CAPTURE: if (int'(r_cnt) == LAST_CAP) w_next = WRITE;
            WRITE:   w_next = DONE;
            DONE:    w_next = DONE;
            default: w_next = IDLE;
        endcase
        if (!start_mat_mul) w_next = IDLE;
    end

    // Row r completes on the same edge its write is registered, so the last
    // element is forwarded straight from the input rather than from r_buf.
    always_comb begin
        w_capture   = start_mat_mul && (r_state == CAPTURE);
        w_row_i     = int'(r_cnt) - ROW0_END;
        w_row       = w_row_i[RW-1:0];
        w_wr_en     = w_capture && (w_row_i >= 0) && (w_row_i < N);
        w_addr_full = 32'(C_BASE + w_row_i);
        w_row_word  = '0;
        for (int j = 0; j < N; j++) begin
            if (j == N - 1)
                w_row_word[j*DWIDTH +: DWIDTH] = c_data_in[w_row*DWIDTH +: DWIDTH];
            else
                w_row_word[j*DWIDTH +: DWIDTH] = r_buf[w_row][j];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_addr  <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            for (int r = 0; r < N; r++)
                for (int j = 0; j < N; j++)
                    r_buf[r][j] <= '0;
        end else begin
            r_state <= w_next;
            r_we    <= w_wr_en;
            r_done  <= (w_next == DONE);
            if (!start_mat_mul)
                r_cnt <= 8'd0;
            else if (r_cnt != 8'hFF)
                r_cnt <= r_cnt + 8'd1;
            if (w_capture) begin
                for (int r = 0; r < N; r++)
                    for (int j = 0; j < N; j++)
                        if (int'(r_cnt) == FIRST_CAPTURE + r + j)
                            r_buf[r][j] <= c_data_in[r*DWIDTH +: DWIDTH];
            end
            if (w_wr_en) begin
                r_addr <= w_addr_full[AWIDTH-1:0];
                r_data <= w_row_word;
            end
        end
    end

    // Gating with start keeps an abort from letting a queued write through.
    assign c_we       = r_we & start_mat_mul;
    assign c_addr     = r_addr;
    assign c_data     = r_data;
    assign done_drain = r_done;

endmodule

// File: tb/tb_matmul_c_drain.sv
// tb/tb_matmul_c_drain.sv - scoreboard bench for matmul_c_drain (two parameterisations)
module tb_matmul_c_drain;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 7;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [N*DW-1:0] din = '0;

    logic [AW-1:0]   addr_a, addr_b;
    logic [N*DW-1:0] data_a, data_b;
    logic            we_a, we_b, done_a, done_b;

    matmul_c_drain u_a (
        .clk(clk), .reset(reset), .start_mat_mul(start), .c_data_in(din),
        .c_addr(addr_a), .c_data(data_a), .c_we(we_a), .done_drain(done_a)
    );

    matmul_c_drain #(.FIRST_CAPTURE(1), .C_BASE(126)) u_b (
        .clk(clk), .reset(reset), .start_mat_mul(start), .c_data_in(din),
        .c_addr(addr_b), .c_data(data_b), .c_we(we_b), .done_drain(done_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [N*DW-1:0] data;
    } wr_t;

    wr_t             q[2][$];
    logic [N*DW-1:0] hist [512];
    int              m_cnt = 0;
    int              n_cmp = 0;
    int              n_err = 0;

    function automatic int fc_of(int i);
        return (i == 0) ? 19 : 1;
    endfunction

    function automatic int cb_of(int i);
        return (i == 0) ? 0 : 126;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic            mon_we, mon_done;
    logic [AW-1:0]   mon_addr;
    logic [N*DW-1:0] mon_data;
    wr_t             mon_e;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mon_we   = (i == 0) ? we_a   : we_b;
            mon_done = (i == 0) ? done_a : done_b;
            mon_addr = (i == 0) ? addr_a : addr_b;
            mon_data = (i == 0) ? data_a : data_b;
            if (mon_we) begin
                if (q[i].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write inst%0d: got addr %0d data %h expected no write (t=%0t)",
                             i, mon_addr, mon_data, $time);
                end else begin
                    mon_e = q[i].pop_front();
                    chk($sformatf("addr inst%0d", i), 64'(mon_addr), 64'(mon_e.addr));
                    chk($sformatf("data inst%0d", i), mon_data, mon_e.data);
                end
            end
            chk($sformatf("done inst%0d", i), 64'(mon_done), 64'(m_cnt >= fc_of(i) + 2*N));
        end
    end

    function automatic logic [15:0] lane(int mode, int r, int k);
        int j;
        j = k - 19 - r;
        if (mode == 1 && j >= 0 && j < N) return {4'(r), 4'(j), 8'h00};
        if (mode == 2 && j >= 0 && j < N) return 16'(32'hA000 + 4*r + j);
        return {2'(r), 9'(k), 5'($urandom)};
    endfunction

    task automatic check_zero(string tag);
        chk({tag, " we_a"},   64'(we_a),   64'd0);
        chk({tag, " addr_a"}, 64'(addr_a), 64'd0);
        chk({tag, " data_a"}, data_a,      64'd0);
        chk({tag, " done_a"}, 64'(done_a), 64'd0);
        chk({tag, " we_b"},   64'(we_b),   64'd0);
        chk({tag, " addr_b"}, 64'(addr_b), 64'd0);
        chk({tag, " data_b"}, data_b,      64'd0);
        chk({tag, " done_b"}, 64'(done_b), 64'd0);
    endtask

    // Each iteration k drives the sample the DUT captures on the edge where cnt==k.
    // A row is expected only if its write cycle (cnt = fc+r+N) falls while start is high.
    task automatic run(int len, int mode, int reset_k);
        wr_t e;
        int  rr, fc;
        for (int k = 0; k < len; k++) begin
            start = 1'b1;
            for (int r = 0; r < N; r++) din[r*DW +: DW] = lane(mode, r, k);
            hist[k] = din;
            for (int i = 0; i < 2; i++) begin
                fc = fc_of(i);
                rr = k - fc - N + 1;
                if (rr >= 0 && rr < N && k + 1 < len) begin
                    e.addr = AW'(cb_of(i) + rr);
                    for (int j = 0; j < N; j++)
                        e.data[j*DW +: DW] = hist[fc + rr + j][rr*DW +: DW];
                    q[i].push_back(e);
                end
            end
            if (k == reset_k) begin
                #2;
                reset = 1'b0;
                #1;
                check_zero("async_reset");
                q[0].delete();
                q[1].delete();
                m_cnt = 0;
                reset = 1'b1;
                return;
            end
            @(posedge clk);
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            #1;
        end
        start = 1'b0;
        repeat (6) begin
            din = {$urandom, $urandom};
            @(posedge clk);
            m_cnt = 0;
            #1;
        end
        chk("rows_missing inst0", 64'(q[0].size()), 64'd0);
        chk("rows_missing inst1", 64'(q[1].size()), 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        reset = 1'b1;
        @(posedge clk);
        #1;
        run(40, 1, -1);
        run(25, 0, -1);
        run(40, 2, -1);
        run(22, 0, 21);
        run(40, 0, -1);
        run(300, 0, -1);
        for (int t = 0; t < 6; t++) run(int'($urandom_range(20, 45)), 0, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
